// File: rtl/dmem_wait.sv
// dmem_wait: request/ready data memory with byte/half/word lanes,
// programmable wait states and a small memory-mapped I/O window.
module dmem_wait #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        signed_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] io_out
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [31:0] r_wdata;
    logic [3:0]  r_wait;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_io_out;
    logic [31:0] r_cyc;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_in_io;
    logic        w_cap_err;
    logic        w_accept;
    logic        w_perform;
    logic        w_io;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rd_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wrep;
    logic        w_mem_we;
    logic        w_io_we;

    // Classify the incoming request: I/O hit and alignment/size errors
    always_comb begin
        w_in_io   = (addr >= IO_BASE);
        w_cap_err = (size == 2'b11)
                  | ((size == 2'b01) & addr[0])
                  | ((size == 2'b10) & (addr[1:0] != 2'b00))
                  | (w_in_io & (size != 2'b10));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next = w_cap_err ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_wait == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs and access strobes
    always_comb begin
        ready     = (r_state == S_RESP);
        w_accept  = (r_state == S_IDLE) && req;
        w_perform = (r_state == S_BUSY) && (r_wait == 4'd0);
    end

    // Decode of the captured request and read-data lane selection
    always_comb begin
        w_io  = (r_addr >= IO_BASE);
        w_idx = r_addr[AW+1:2];

        w_rd_word = '0;
        if (w_io) begin
            if (r_addr == IO_BASE) begin
                w_rd_word = r_io_out;
            end else if (r_addr == IO_BASE + 32'd4) begin
                w_rd_word = r_cyc;
            end
        end else begin
            w_rd_word = r_mem[w_idx];
        end

        case (r_addr[1:0])
            2'd0:    w_byte = w_rd_word[7:0];
            2'd1:    w_byte = w_rd_word[15:8];
            2'd2:    w_byte = w_rd_word[23:16];
            default: w_byte = w_rd_word[31:24];
        endcase
        w_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = w_rd_word;
        endcase
    end

    // Store lane enables and right-aligned data replicated onto every lane
    always_comb begin
        case (r_size)
            2'b00: begin
                w_be   = 4'b0001 << r_addr[1:0];
                w_wrep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wrep = r_wdata;
            end
        endcase
        w_mem_we = w_perform & r_we & ~w_io;
        w_io_we  = w_perform & r_we & w_io & (r_addr == IO_BASE);
    end

    // Request capture, wait countdown and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_sext  <= 1'b0;
            r_wdata <= '0;
            r_wait  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= addr;
            r_we    <= we;
            r_size  <= size;
            r_sext  <= signed_ld;
            r_wdata <= wdata;
            r_wait  <= 4'(WAIT_STATES);
            if (w_cap_err) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end else if (r_state == S_BUSY) begin
            if (r_wait != 4'd0) begin
                r_wait <= r_wait - 4'd1;
            end else begin
                r_rdata <= r_we ? '0 : w_load;
                r_err   <= 1'b0;
            end
        end
    end

    // RAM byte-lane writes; reset suppresses a store that has not yet committed
    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wrep[8*k +: 8];
                end
            end
        end
    end

    // I/O output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_out <= '0;
        end else if (w_io_we) begin
            r_io_out <= r_wdata;
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
        end
    end

    assign rdata  = r_rdata;
    assign err    = r_err;
    assign io_out = r_io_out;

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: one instance with no wait states, one with three.
module tb_dmem_wait;

    logic        clk = 1'b0;
    logic        reset0, reset1;
    logic        req0, req1;
    logic        we;
    logic [1:0]  size;
    logic        signed_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1, io_out0, io_out1;
    logic        ready0, ready1, err0, err1;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] IOB = 32'hFFFF_0000;

    always #5 clk = ~clk;

    dmem_wait #(.DEPTH_WORDS(64), .WAIT_STATES(0), .IO_BASE(IOB)) u_dut0 (
        .clk(clk), .reset(reset0), .req(req0), .we(we), .size(size),
        .signed_ld(signed_ld), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .err(err0), .io_out(io_out0)
    );

    dmem_wait #(.DEPTH_WORDS(64), .WAIT_STATES(3), .IO_BASE(IOB)) u_dut1 (
        .clk(clk), .reset(reset1), .req(req1), .we(we), .size(size),
        .signed_ld(signed_ld), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .err(err1), .io_out(io_out1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access from IDLE; returns latency in cycles (0 if no ready seen)
    task automatic access(input bit sel, input logic a_we, input logic [1:0] a_size,
                          input logic a_sext, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                          output int lat, output logic [31:0] rd, output logic er);
        we = a_we; size = a_size; signed_ld = a_sext; addr = a_addr; wdata = a_wdata;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        lat = 0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (sel ? ready1 : ready0) begin
                lat = c;
                rd  = sel ? rdata1 : rdata0;
                er  = sel ? err1 : err0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input string tag, input bit sel, input logic a_we, input logic [1:0] a_size,
                        input logic a_sext, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                        input int exp_lat, input logic exp_err, input bit chk_rd, input logic [31:0] exp_rd);
        int          lat;
        logic [31:0] rd;
        logic        er;
        access(sel, a_we, a_size, a_sext, a_addr, a_wdata, lat, rd, er);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          pulses;
        logic [31:0] v1, v2;
        logic        er;

        reset0 = 1'b1; reset1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
        we = 1'b0; size = 2'b00; signed_ld = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset0 = 1'b0; reset1 = 1'b0;

        check("rst_ready", {31'd0, ready0}, 32'd0);
        check("rst_err",   {31'd0, err0},   32'd0);
        check("rst_rdata", rdata0,          32'd0);
        check("rst_io",    io_out0,         32'd0);

        // word round trip and byte/half lanes, no wait states
        xfer("st_w10",   0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 0, 0, '0);
        xfer("ld_w10",   0, 0, 2'b10, 0, 32'h10, '0, 2, 0, 1, 32'hDEADBEEF);
        xfer("ld_sb13",  0, 0, 2'b00, 1, 32'h13, '0, 2, 0, 1, 32'hFFFFFFDE);
        xfer("ld_uh10",  0, 0, 2'b01, 0, 32'h10, '0, 2, 0, 1, 32'h0000BEEF);
        xfer("ld_sh12",  0, 0, 2'b01, 1, 32'h12, '0, 2, 0, 1, 32'hFFFFDEAD);
        xfer("ld_ub10",  0, 0, 2'b00, 0, 32'h10, '0, 2, 0, 1, 32'h000000EF);
        xfer("st_b11",   0, 1, 2'b00, 0, 32'h11, 32'hAAAAAA55, 2, 0, 0, '0);
        xfer("ld_w10b",  0, 0, 2'b10, 0, 32'h10, '0, 2, 0, 1, 32'hDEAD55EF);

        // misalignment and reserved size
        xfer("st_w20",   0, 1, 2'b10, 0, 32'h20, 32'h11223344, 2, 0, 0, '0);
        xfer("mis_lw12", 0, 0, 2'b10, 0, 32'h12, '0, 1, 1, 1, 32'h0);
        xfer("mis_sh21", 0, 1, 2'b01, 0, 32'h21, 32'h0000BBCC, 1, 1, 1, 32'h0);
        xfer("rsv_sz",   0, 0, 2'b11, 0, 32'h20, '0, 1, 1, 1, 32'h0);
        xfer("ld_w20",   0, 0, 2'b10, 0, 32'h20, '0, 2, 0, 1, 32'h11223344);
        xfer("ld_w10c",  0, 0, 2'b10, 0, 32'h10, '0, 2, 0, 1, 32'hDEAD55EF);

        // I/O window
        xfer("io_st",    0, 1, 2'b10, 0, IOB, 32'h000000A5, 2, 0, 0, '0);
        check("io_out", io_out0, 32'h000000A5);
        xfer("io_ld",    0, 0, 2'b10, 0, IOB, '0, 2, 0, 1, 32'h000000A5);
        access(0, 0, 2'b10, 0, IOB + 32'd4, '0, lat, v1, er);
        repeat (7) begin @(posedge clk); #1; end
        access(0, 0, 2'b10, 0, IOB + 32'd4, '0, lat, v2, er);
        check("cyc_delta", v2 - v1, 32'd10);
        xfer("io_sb",    0, 1, 2'b00, 0, IOB, 32'h000000FF, 1, 1, 1, 32'h0);
        xfer("io_lh",    0, 0, 2'b01, 0, IOB, '0, 1, 1, 1, 32'h0);
        check("io_keep", io_out0, 32'h000000A5);
        xfer("io_stcyc", 0, 1, 2'b10, 0, IOB + 32'd4, 32'h12345678, 2, 0, 0, '0);
        xfer("io_ld8",   0, 0, 2'b10, 0, IOB + 32'd8, '0, 2, 0, 1, 32'h0);
        check("io_keep2", io_out0, 32'h000000A5);

        // wait states and address wrap (64 words -> 256-byte wrap)
        xfer("ws_st108", 1, 1, 2'b10, 0, 32'h108, 32'hCAFEF00D, 5, 0, 0, '0);
        xfer("ws_ld8",   1, 0, 2'b10, 0, 32'h8, '0, 5, 0, 1, 32'hCAFEF00D);

        // reset while a store is still counting down
        we = 1'b1; size = 2'b10; signed_ld = 1'b0; addr = 32'h8; wdata = 32'h12345678;
        req1 = 1'b1;
        pulses = 0;
        @(posedge clk); #1;
        req1 = 1'b0;
        if (ready1) pulses++;
        @(posedge clk); #1;
        if (ready1) pulses++;
        reset1 = 1'b1;
        @(posedge clk); #1;
        reset1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (ready1) pulses++;
            @(posedge clk); #1;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_ready",  {31'd0, ready1}, 32'd0);
        check("abort_err",    {31'd0, err1},   32'd0);
        check("abort_rdata",  rdata1,          32'd0);
        check("abort_io",     io_out1,         32'd0);
        xfer("abort_ld8", 1, 0, 2'b10, 0, 32'h8, '0, 5, 0, 1, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
